// File: rtl/instr_encoder.sv
// MIPS32 instruction encoder: decoded op + operand fields -> 32-bit word with fetch address, via output FIFO.
// Optional re-decode self-check guarded by ENCODER_SELFCHECK_EN.

package instr_encoder_pkg;
  typedef enum logic [5:0] {
    OP_NOP, OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_JR, OP_JALR,
    OP_SYSCALL, OP_BREAK, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL, OP_J, OP_JAL,
    OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
    OP_MFC0, OP_MTC0, OP_ERET, OP_MUL,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_DECODE_ERROR
  } op_t;
endpackage

module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  op_t         in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_sa,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [31:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [31:0] fmt_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] fmt_i(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  logic [31:0] w_word;
  logic        w_bad;
  logic        w_err;

  always_comb begin
    w_word = '0;
    w_bad  = 1'b0;
    case (in_op)
      OP_NOP:     w_word = '0;
      OP_SLL:     w_word = fmt_r(5'd0, in_rt, in_rd, in_sa, 6'h00);
      OP_SRL:     w_word = fmt_r(5'd0, in_rt, in_rd, in_sa, 6'h02);
      OP_SRA:     w_word = fmt_r(5'd0, in_rt, in_rd, in_sa, 6'h03);
      OP_SLLV:    w_word = fmt_r(in_rs, in_rt, in_rd, 5'd0, 6'h04);
      OP_SRLV:    w_word = fmt_r(in_rs, in_rt, in_rd, 5'd0, 6'h06);
      OP_SRAV:    w_word = fmt_r(in_rs, in_rt, in_rd, 5'd0, 6'h07);
      OP_JR:      w_word = fmt_r(in_rs, 5'd0, 5'd0, 5'd0, 6'h08);
      OP_JALR:    w_word = fmt_r(in_rs, 5'd0, in_rd, 5'd0, 6'h09);
      OP_SYSCALL: w_word = {6'b000000, in_target[19:0], 6'h0C};
      OP_BREAK:   w_word = {6'b000000, in_target[19:0], 6'h0D};
      OP_MFHI:    w_word = fmt_r(5'd0, 5'd0, in_rd, 5'd0, 6'h10);
      OP_MTHI:    w_word = fmt_r(in_rs, 5'd0, 5'd0, 5'd0, 6'h11);
      OP_MFLO:    w_word = fmt_r(5'd0, 5'd0, in_rd, 5'd0, 6'h12);
      OP_MTLO:    w_word = fmt_r(in_rs, 5'd0, 5'd0, 5'd0, 6'h13);
      OP_MULT:    w_word = fmt_r(in_rs, in_rt, 5'd0, 5'd0, 6'h18);
      OP_MULTU:   w_word = fmt_r(in_rs, in_rt, 5'd0, 5'd0, 6'h19);
      OP_DIV:     w_word = fmt_r(in_rs, in_rt, 5'd0, 5'd0, 6'h1A);
      OP_DIVU:    w_word = fmt_r(in_rs, in_rt, 5'd0, 5'd0, 6'h1B);
      OP_ADD:     w_word = fmt_r(in_rs, in_rt, in_rd, 5'd0, 6'h20);
      OP_ADDU:    w_word = fmt_r(in_rs, in_rt, in_rd, 5'd0, 6'h21);
      OP_SUB:     w_word = fmt_r(in_rs, in_rt, in_rd, 5'd0, 6'h22);
      OP_SUBU:    w_word = fmt_r(in_rs, in_rt, in_rd, 5'd0, 6'h23);
      OP_AND:     w_word = fmt_r(in_rs, in_rt, in_rd, 5'd0, 6'h24);
      OP_OR:      w_word = fmt_r(in_rs, in_rt, in_rd, 5'd0, 6'h25);
      OP_XOR:     w_word = fmt_r(in_rs, in_rt, in_rd, 5'd0, 6'h26);
      OP_NOR:     w_word = fmt_r(in_rs, in_rt, in_rd, 5'd0, 6'h27);
      OP_SLT:     w_word = fmt_r(in_rs, in_rt, in_rd, 5'd0, 6'h2A);
      OP_SLTU:    w_word = fmt_r(in_rs, in_rt, in_rd, 5'd0, 6'h2B);
      OP_BLTZ:    w_word = fmt_i(6'h01, in_rs, 5'b00000, in_imm);
      OP_BGEZ:    w_word = fmt_i(6'h01, in_rs, 5'b00001, in_imm);
      OP_BLTZAL:  w_word = fmt_i(6'h01, in_rs, 5'b10000, in_imm);
      OP_BGEZAL:  w_word = fmt_i(6'h01, in_rs, 5'b10001, in_imm);
      OP_J:       w_word = {6'h02, in_target};
      OP_JAL:     w_word = {6'h03, in_target};
      OP_BEQ:     w_word = fmt_i(6'h04, in_rs, in_rt, in_imm);
      OP_BNE:     w_word = fmt_i(6'h05, in_rs, in_rt, in_imm);
      OP_BLEZ:    w_word = fmt_i(6'h06, in_rs, 5'd0, in_imm);
      OP_BGTZ:    w_word = fmt_i(6'h07, in_rs, 5'd0, in_imm);
      OP_ADDI:    w_word = fmt_i(6'h08, in_rs, in_rt, in_imm);
      OP_ADDIU:   w_word = fmt_i(6'h09, in_rs, in_rt, in_imm);
      OP_SLTI:    w_word = fmt_i(6'h0A, in_rs, in_rt, in_imm);
      OP_SLTIU:   w_word = fmt_i(6'h0B, in_rs, in_rt, in_imm);
      OP_ANDI:    w_word = fmt_i(6'h0C, in_rs, in_rt, in_imm);
      OP_ORI:     w_word = fmt_i(6'h0D, in_rs, in_rt, in_imm);
      OP_XORI:    w_word = fmt_i(6'h0E, in_rs, in_rt, in_imm);
      OP_LUI:     w_word = fmt_i(6'h0F, 5'd0, in_rt, in_imm);
      OP_MFC0:    w_word = {6'h10, 5'b00000, in_rt, in_rd, 8'h00, in_sa[2:0]};
      OP_MTC0:    w_word = {6'h10, 5'b00100, in_rt, in_rd, 8'h00, in_sa[2:0]};
      OP_ERET:    w_word = 32'h4200_0018;
      OP_MUL:     w_word = {6'h1C, in_rs, in_rt, in_rd, 5'd0, 6'h02};
      OP_LB:      w_word = fmt_i(6'h20, in_rs, in_rt, in_imm);
      OP_LH:      w_word = fmt_i(6'h21, in_rs, in_rt, in_imm);
      OP_LW:      w_word = fmt_i(6'h23, in_rs, in_rt, in_imm);
      OP_LBU:     w_word = fmt_i(6'h24, in_rs, in_rt, in_imm);
      OP_LHU:     w_word = fmt_i(6'h25, in_rs, in_rt, in_imm);
      OP_SB:      w_word = fmt_i(6'h28, in_rs, in_rt, in_imm);
      OP_SH:      w_word = fmt_i(6'h29, in_rs, in_rt, in_imm);
      OP_SW:      w_word = fmt_i(6'h2B, in_rs, in_rt, in_imm);
      default: begin
        w_word = '0;
        w_bad  = 1'b1;
      end
    endcase
  end

`ifdef ENCODER_SELFCHECK_EN
  // Fetch-stage decoder; rejects words whose must-be-zero fields are set.
  function automatic op_t decode_word(input logic [31:0] w);
    logic [5:0] opc;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sa;
    op_t        op;
    opc = w[31:26];
    rs  = w[25:21];
    rt  = w[20:16];
    rd  = w[15:11];
    sa  = w[10:6];
    fn  = w[5:0];
    op  = OP_DECODE_ERROR;
    case (opc)
      6'h00: begin
        case (fn)
          6'h00: if (rs == '0) op = (rd == '0) ? OP_NOP : OP_SLL;
          6'h02: if (rs == '0) op = OP_SRL;
          6'h03: if (rs == '0) op = OP_SRA;
          6'h04: if (sa == '0) op = OP_SLLV;
          6'h06: if (sa == '0) op = OP_SRLV;
          6'h07: if (sa == '0) op = OP_SRAV;
          6'h08: if (rt == '0 && rd == '0 && sa == '0) op = OP_JR;
          6'h09: if (rt == '0 && sa == '0) op = OP_JALR;
          6'h0C: op = OP_SYSCALL;
          6'h0D: op = OP_BREAK;
          6'h10: if (rs == '0 && rt == '0 && sa == '0) op = OP_MFHI;
          6'h11: if (rt == '0 && rd == '0 && sa == '0) op = OP_MTHI;
          6'h12: if (rs == '0 && rt == '0 && sa == '0) op = OP_MFLO;
          6'h13: if (rt == '0 && rd == '0 && sa == '0) op = OP_MTLO;
          6'h18: if (rd == '0 && sa == '0) op = OP_MULT;
          6'h19: if (rd == '0 && sa == '0) op = OP_MULTU;
          6'h1A: if (rd == '0 && sa == '0) op = OP_DIV;
          6'h1B: if (rd == '0 && sa == '0) op = OP_DIVU;
          6'h20: if (sa == '0) op = OP_ADD;
          6'h21: if (sa == '0) op = OP_ADDU;
          6'h22: if (sa == '0) op = OP_SUB;
          6'h23: if (sa == '0) op = OP_SUBU;
          6'h24: if (sa == '0) op = OP_AND;
          6'h25: if (sa == '0) op = OP_OR;
          6'h26: if (sa == '0) op = OP_XOR;
          6'h27: if (sa == '0) op = OP_NOR;
          6'h2A: if (sa == '0) op = OP_SLT;
          6'h2B: if (sa == '0) op = OP_SLTU;
          default: op = OP_DECODE_ERROR;
        endcase
      end
      6'h01: begin
        case (rt)
          5'b00000: op = OP_BLTZ;
          5'b00001: op = OP_BGEZ;
          5'b10000: op = OP_BLTZAL;
          5'b10001: op = OP_BGEZAL;
          default:  op = OP_DECODE_ERROR;
        endcase
      end
      6'h02: op = OP_J;
      6'h03: op = OP_JAL;
      6'h04: op = OP_BEQ;
      6'h05: op = OP_BNE;
      6'h06: if (rt == '0) op = OP_BLEZ;
      6'h07: if (rt == '0) op = OP_BGTZ;
      6'h08: op = OP_ADDI;
      6'h09: op = OP_ADDIU;
      6'h0A: op = OP_SLTI;
      6'h0B: op = OP_SLTIU;
      6'h0C: op = OP_ANDI;
      6'h0D: op = OP_ORI;
      6'h0E: op = OP_XORI;
      6'h0F: if (rs == '0) op = OP_LUI;
      6'h10: begin
        if (w == 32'h4200_0018)                    op = OP_ERET;
        else if (w[10:3] == '0 && rs == 5'b00000)  op = OP_MFC0;
        else if (w[10:3] == '0 && rs == 5'b00100)  op = OP_MTC0;
      end
      6'h1C: if (sa == '0 && fn == 6'h02) op = OP_MUL;
      6'h20: op = OP_LB;
      6'h21: op = OP_LH;
      6'h23: op = OP_LW;
      6'h24: op = OP_LBU;
      6'h25: op = OP_LHU;
      6'h28: op = OP_SB;
      6'h29: op = OP_SH;
      6'h2B: op = OP_SW;
      default: op = OP_DECODE_ERROR;
    endcase
    return op;
  endfunction

  assign w_err = w_bad | (decode_word(w_word) != in_op);
`else
  assign w_err = w_bad;
`endif

  logic [31:0]    r_instr_mem [DEPTH];
  logic [31:0]    r_addr_mem  [DEPTH];
  logic [DEPTH-1:0] r_err_mem;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_occ;
  logic [31:0]    r_addr_ptr;
  logic [31:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_occ == (AW+1)'(DEPTH));
  assign w_empty = (r_occ == '0);
  // Flush discards both handshakes; in_ready itself is left as computed.
  assign w_push  = in_valid & ~w_full & ~flush;
  assign w_pop   = ~w_empty & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_addr_ptr <= BASE_ADDR;
      r_count    <= '0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_addr_ptr <= BASE_ADDR;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + AW'(1);
        r_addr_ptr <= r_addr_ptr + 32'd4;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count  <= r_count + 32'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + (AW+1)'(1);
        2'b01:   r_occ <= r_occ - (AW+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= w_word;
      r_addr_mem[r_wr_ptr]  <= r_addr_ptr;
      r_err_mem[r_wr_ptr]   <= w_err;
    end
  end

  // Empty FIFO presents a zero word tagged with the next address to be assigned.
  always_comb begin
    in_ready  = ~w_full;
    out_valid = ~w_empty;
    count     = r_count;
    if (w_empty) begin
      out_instr = '0;
      out_addr  = r_addr_ptr;
      out_err   = 1'b0;
    end else begin
      out_instr = r_instr_mem[r_rd_ptr];
      out_addr  = r_addr_mem[r_rd_ptr];
      out_err   = r_err_mem[r_rd_ptr];
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed steps plus random traffic against a table-driven model.
// Expected out_err for SLL rd=0 follows ENCODER_SELFCHECK_EN.

module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'hBFC0_0000;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  op_t         in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_sa;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [31:0] count;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa),
    .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Encoding table: major opcode, funct, fixed rs/rt, and which operand fields are used.
  typedef struct {
    bit    known;
    int    opc;
    int    fn;
    int    frs;
    int    frt;
    string uses;
  } ent_t;

  typedef struct {
    logic [31:0] w;
    logic [31:0] a;
    logic        e;
  } item_t;

  ent_t  tbl [64];
  item_t q[$];
  item_t seen[$];
  logic [31:0] m_addr;
  logic [31:0] m_cnt;
  int errors = 0;
  int checks = 0;
  int n_acc  = 0;

  function automatic void def(op_t op, int opc, int fn, string uses, int frs = 0, int frt = 0);
    tbl[int'(op)] = '{known: 1'b1, opc: opc, fn: fn, frs: frs, frt: frt, uses: uses};
  endfunction

  function automatic void build_table();
    for (int i = 0; i < 64; i++) tbl[i] = '{known: 1'b0, opc: 0, fn: 0, frs: 0, frt: 0, uses: ""};
    def(OP_NOP, 0, 0, "");
    def(OP_SLL, 0, 'h00, "tda");  def(OP_SRL, 0, 'h02, "tda");  def(OP_SRA, 0, 'h03, "tda");
    def(OP_SLLV, 0, 'h04, "std"); def(OP_SRLV, 0, 'h06, "std"); def(OP_SRAV, 0, 'h07, "std");
    def(OP_JR, 0, 'h08, "s");     def(OP_JALR, 0, 'h09, "sd");
    def(OP_SYSCALL, 0, 'h0C, "c"); def(OP_BREAK, 0, 'h0D, "c");
    def(OP_MFHI, 0, 'h10, "d");   def(OP_MTHI, 0, 'h11, "s");
    def(OP_MFLO, 0, 'h12, "d");   def(OP_MTLO, 0, 'h13, "s");
    def(OP_MULT, 0, 'h18, "st");  def(OP_MULTU, 0, 'h19, "st");
    def(OP_DIV, 0, 'h1A, "st");   def(OP_DIVU, 0, 'h1B, "st");
    def(OP_ADD, 0, 'h20, "std");  def(OP_ADDU, 0, 'h21, "std");
    def(OP_SUB, 0, 'h22, "std");  def(OP_SUBU, 0, 'h23, "std");
    def(OP_AND, 0, 'h24, "std");  def(OP_OR, 0, 'h25, "std");
    def(OP_XOR, 0, 'h26, "std");  def(OP_NOR, 0, 'h27, "std");
    def(OP_SLT, 0, 'h2A, "std");  def(OP_SLTU, 0, 'h2B, "std");
    def(OP_BLTZ, 1, 0, "si", 0, 0);   def(OP_BGEZ, 1, 0, "si", 0, 1);
    def(OP_BLTZAL, 1, 0, "si", 0, 16); def(OP_BGEZAL, 1, 0, "si", 0, 17);
    def(OP_J, 2, 0, "j");         def(OP_JAL, 3, 0, "j");
    def(OP_BEQ, 4, 0, "sti");     def(OP_BNE, 5, 0, "sti");
    def(OP_BLEZ, 6, 0, "si");     def(OP_BGTZ, 7, 0, "si");
    def(OP_ADDI, 8, 0, "sti");    def(OP_ADDIU, 9, 0, "sti");
    def(OP_SLTI, 10, 0, "sti");   def(OP_SLTIU, 11, 0, "sti");
    def(OP_ANDI, 12, 0, "sti");   def(OP_ORI, 13, 0, "sti");
    def(OP_XORI, 14, 0, "sti");   def(OP_LUI, 15, 0, "ti");
    def(OP_MFC0, 16, 0, "tde", 0); def(OP_MTC0, 16, 0, "tde", 4);
    def(OP_ERET, 16, 'h18, "", 16);
    def(OP_MUL, 28, 2, "std");
    def(OP_LB, 32, 0, "sti");  def(OP_LH, 33, 0, "sti");  def(OP_LW, 35, 0, "sti");
    def(OP_LBU, 36, 0, "sti"); def(OP_LHU, 37, 0, "sti");
    def(OP_SB, 40, 0, "sti");  def(OP_SH, 41, 0, "sti");  def(OP_SW, 43, 0, "sti");
  endfunction

  // Reference: word = opcode*2^26 + rs*2^21 + rt*2^16 + rd*2^11 + sa*2^6 + funct, unused fields zero.
  function automatic logic [32:0] model_enc(op_t op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                            logic [4:0] sa, logic [15:0] imm, logic [25:0] tgt);
    ent_t        t;
    logic [31:0] w;
    logic        e;
    t = tbl[int'(op)];
    if (!t.known) return {1'b1, 32'h0};
    w = 32'(t.opc) * 32'h0400_0000 + 32'(t.frs) * 32'h20_0000 + 32'(t.frt) * 32'h1_0000 + 32'(t.fn);
    for (int i = 0; i < t.uses.len(); i++) begin
      case (t.uses[i])
        "s": w = w + 32'(rs) * 32'h20_0000;
        "t": w = w + 32'(rt) * 32'h1_0000;
        "d": w = w + 32'(rd) * 32'h800;
        "a": w = w + 32'(sa) * 32'h40;
        "i": w = w + 32'(imm);
        "j": w = w + 32'(tgt);
        "c": w = w + 32'(tgt[19:0]) * 32'h40;
        "e": w = w + 32'(sa[2:0]);
        default: ;
      endcase
    end
    e = 1'b0;
`ifdef ENCODER_SELFCHECK_EN
    if (op == OP_SLL && rd == 5'd0) e = 1'b1;
`endif
    return {e, w};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge, then advance the model at posedge.
  task automatic cycle();
    logic        push;
    logic        pop;
    logic [32:0] enc;
    @(negedge clk);
    if (resetn) begin
      chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("count", count, m_cnt);
      if (q.size() != 0) begin
        chk("head_instr", out_instr, q[0].w);
        chk("head_addr", out_addr, q[0].a);
        chk("head_err", 32'(out_err), 32'(q[0].e));
      end else begin
        chk("empty_instr", out_instr, 32'h0);
        chk("empty_err", 32'(out_err), 32'h0);
      end
    end
    push = resetn && !flush && in_valid && (q.size() < DEPTH);
    pop  = resetn && !flush && out_ready && (q.size() != 0);
    enc  = model_enc(in_op, in_rs, in_rt, in_rd, in_sa, in_imm, in_target);
    if (pop) seen.push_back('{w: out_instr, a: out_addr, e: out_err});
    if (resetn && !flush && in_valid && in_ready) n_acc++;
    @(posedge clk);
    if (!resetn || flush) begin
      q.delete();
      m_addr = BASE;
      m_cnt  = '0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      if (push) begin
        q.push_back('{w: enc[31:0], a: m_addr, e: enc[32]});
        m_addr = m_addr + 32'd4;
      end
    end
    #1;
  endtask

  task automatic drive(input op_t op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [4:0] sa, input logic [15:0] imm, input logic [25:0] tgt);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_sa = sa; in_imm = imm; in_target = tgt;
  endtask

  task automatic do_reset();
    resetn = 1'b0; in_valid = 1'b0; flush = 1'b0;
    cycle();
    resetn = 1'b1;
    seen.delete();
  endtask

  initial begin
    build_table();
    m_addr = BASE; m_cnt = '0;
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(OP_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    repeat (2) cycle();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'h0);
    chk("rst_count", count, 32'h0);
    resetn = 1'b1;

    // ADDIU, visible one cycle after acceptance
    drive(OP_ADDIU, 5'd29, 5'd29, 5'd7, 5'd3, 16'hFFF8, 26'h3ABCDEF);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("addiu_valid", 32'(out_valid), 32'h1);
    chk("addiu_instr", out_instr, 32'h27BD_FFF8);
    chk("addiu_addr", out_addr, 32'hBFC0_0000);
    chk("addiu_err", 32'(out_err), 32'h0);

    // LW / JR / ERET stream
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(OP_LW, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);   cycle();
    drive(OP_JR, 5'd31, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);      cycle();
    drive(OP_ERET, 5'd5, 5'd6, 5'd7, 5'd1, 16'h1234, 26'h1);  cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) if (seen.size() < 3) cycle();
    chk("stream_n", 32'(seen.size()), 32'd3);
    if (seen.size() >= 3) begin
      chk("stream_w0", seen[0].w, 32'h8FA8_0004); chk("stream_a0", seen[0].a, 32'hBFC0_0000);
      chk("stream_w1", seen[1].w, 32'h03E0_0008); chk("stream_a1", seen[1].a, 32'hBFC0_0004);
      chk("stream_w2", seen[2].w, 32'h4200_0018); chk("stream_a2", seen[2].a, 32'hBFC0_0008);
    end
    chk("stream_count", count, 32'd3);

    // Fill to DEPTH with consumer stalled, then drain in order
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    n_acc     = 0;
    for (int k = 0; k < 6; k++) begin
      drive(OP_ADDU, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
      cycle();
    end
    chk("full_accepts", 32'(n_acc), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) cycle();
    chk("drain_n", 32'(seen.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < seen.size()) chk("drain_addr", seen[k].a, BASE + 32'(4 * k));
    chk("drain_count", count, 32'd4);

    // DECODE_ERROR still consumes an address slot
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(OP_DECODE_ERROR, 5'd3, 5'd4, 5'd5, 5'd6, 16'h7777, 26'h1555);  cycle();
    drive(OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);                cycle();
    in_valid = 1'b0;
    chk("derr_instr", out_instr, 32'h0);
    chk("derr_err", 32'(out_err), 32'h1);
    out_ready = 1'b1;
    cycle();
    chk("derr_next_addr", out_addr, 32'hBFC0_0004);
    chk("derr_next_err", 32'(out_err), 32'h0);
    chk("derr_next_instr", out_instr, 32'h0022_1821);

    // Flush with two queued words and a pending input
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(OP_ORI, 5'd2, 5'd3, 5'd0, 5'd0, 16'h00FF, 26'h0); cycle();
    drive(OP_XORI, 5'd4, 5'd5, 5'd0, 5'd0, 16'hF0F0, 26'h0); cycle();
    out_ready = 1'b0;
    drive(OP_SW, 5'd6, 5'd7, 5'd0, 5'd0, 16'h0010, 26'h0);   cycle();
    chk("preflush_count", count, 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_count", count, 32'h0);
    in_valid = 1'b1;
    drive(OP_ADDIU, 5'd29, 5'd29, 5'd0, 5'd0, 16'hFFF8, 26'h0);
    cycle();
    in_valid = 1'b0;
    chk("postflush_addr", out_addr, 32'hBFC0_0000);

    // SLL rd=0: same word either way, error only with the re-decode check
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(OP_SLL, 5'd9, 5'd1, 5'd0, 5'd2, 16'hABCD, 26'h2AAAAAA);
    cycle();
    in_valid = 1'b0;
    chk("sll_instr", out_instr, 32'h0001_0080);
`ifdef ENCODER_SELFCHECK_EN
    chk("sll_err", 32'(out_err), 32'h1);
`else
    chk("sll_err", 32'(out_err), 32'h0);
`endif

    // Random traffic with occasional flush and reset
    do_reset();
    for (int k = 0; k < 800; k++) begin
      drive(op_t'(6'($urandom_range(0, 63))), 5'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), 16'($urandom), 26'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      resetn    = ($urandom_range(0, 127) != 0);
      cycle();
    end
    resetn = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the fetch-stage op decoder: accepts decoded MIPS32 operations (op_t plus operand fields) and produces 32-bit instruction words.
- Each emitted word is tagged with a sequential fetch address.
- Used by the self-test instruction loader and the trace-replay bench to stream programs into instruction RAM.
- Valid/ready on input and output, with an internal output FIFO.

Parameters:
DEPTH, 4, output FIFO entries (power of two, >=2)
BASE_ADDR, 32'hBFC0_0000, address tagged on the first word after reset/flush

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
flush  in  1  drop FIFO contents, reload address counter to BASE_ADDR
in_valid  in  1  operation offered
in_ready  out  1  encoder can accept
in_op  in  op_t  operation to encode
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field
in_sa  in  5  shamt; [2:0] doubles as CP0 sel for MFC0/MTC0
in_imm  in  16  immediate/offset
in_target  in  26  J/JAL target; [19:0] is the SYSCALL/BREAK code
out_valid  out  1  word available
out_ready  in  1  consumer takes word
out_instr  out  32  encoded instruction
out_addr  out  32  fetch address of out_instr
out_err  out  1  op was not encodable
count  out  32  total words emitted since reset/flush

Behaviour:
- Reset: all FIFO entries invalid; out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, count=0, in_ready=1. Reset dominates flush and every handshake.
- Encoding is combinational from in_* and written into the FIFO on the input handshake (in_valid & in_ready). Latency: word is visible at out_* the cycle after acceptance when the FIFO was empty.
- Formats:
  - R-type: opcode 000000, rs/rt/rd/sa, funct as in the decode table.
  - REGIMM: opcode 000001, rt=00000/00001/10000/10001 for BLTZ/BGEZ/BLTZAL/BGEZAL.
  - I-type: opcode, rs, rt, imm.
  - J/JAL: opcode, target.
  - SYSCALL/BREAK: code in [25:6].
  - MFC0/MTC0: 010000, rs=00000/00100, rt, rd, zeros, sel.
  - ERET: 32'h42000018. NOP: 32'h0. MUL: 011100, rs, rt, rd, 00000, 000010.
  - Fields not used by the format are forced to 0.
- DECODE_ERROR or any unlisted op: word=32'h0, out_err=1. The entry still consumes an address slot.
- in_ready = !full. Simultaneous push and pop on a full FIFO is not allowed (in_ready is already low). Push and pop on a non-empty, non-full FIFO keeps occupancy unchanged.
- out_* come from the FIFO head and are held stable while out_valid & !out_ready.
- out_addr: internal pointer starts at BASE_ADDR and advances +4 per accepted input. Each entry stores its own address. Wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- count: increments on each output handshake; wraps modulo 2^32.
- flush (synchronous, 1 cycle): FIFO emptied, pointer=BASE_ADDR, count=0. An input or output handshake in the same cycle is discarded and not counted; in_ready stays as computed.
- Reset or flush mid-stream: no partial word is ever emitted.

Optional Feature:
ENCODER_SELFCHECK_EN
- Defined: the encoded word is re-decoded with the fetch-stage op decoder before the FIFO write. If the decoded op differs from in_op, out_err=1 for that entry and the word is still stored. Example: SLL with rd=0 decodes as NOP, so it is flagged.
- Undefined: out_err is set only for DECODE_ERROR or unlisted ops. No decoder is instantiated.

Test Plan:
- ADDIU rs=29 rt=29 imm=16'hFFF8 after reset -> out_instr=32'h27BDFFF8, out_addr=32'hBFC00000, err=0, one cycle after accept.
- Stream LW rt=8 rs=29 imm=4; JR rs=31; ERET -> 32'h8FA80004 @BFC00000, 32'h03E00008 @BFC00004, 32'h42000018 @BFC00008; count=3.
- out_ready=0, DEPTH=4, continuous in_valid -> exactly 4 accepts then in_ready=0; release out_ready -> in-order drain, no loss or duplication.
- in_op=DECODE_ERROR -> out_instr=0, out_err=1, next word's address still +4.
- flush with 2 queued words and in_valid=1 -> out_valid=0 next cycle, count=0, next accepted word tagged BFC00000.
- SLL rd=0 rt=1 sa=2: with ENCODER_SELFCHECK_EN -> word 32'h00010080, err=1; without -> same word, err=0.
